// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the data-RAM line-port arbiter.
package dram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      WAIT_R = 2'd2,
      WAIT_W = 2'd3
   } state_e;

   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_MON = 1'b1
   } req_id_e;

   localparam int ADR_W = 28;
   localparam logic [127:0] TIMEOUT_DATA = {4{32'hDEADBEEF}};

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-requester picker: a single request always wins; a tie goes to the
// monitor when prio is set, otherwise to the requester that was not granted last.
module arb_rr2
   import dram_arb_pkg::*;
(
   input  logic [1:0] reqs,
   input  req_id_e    last,
   input  logic       prio,
   output req_id_e    winner
);

   always_comb begin
      winner = REQ_CPU;
      if (reqs == 2'b10) begin
         winner = REQ_MON;
      end else if (reqs == 2'b11) begin
         if (prio || (last == REQ_CPU)) begin
            winner = REQ_MON;
         end
      end
   end

endmodule

// File: rtl/dram_port_arb.sv
// Arbiter and sequencer for the single 128-bit data-RAM line port (CPU refill vs. UART monitor).
// Define ARB_TIMEOUT_EN to add a wait-state watchdog that completes a stuck transaction with err.
module dram_port_arb
   import dram_arb_pkg::*;
#(
   parameter int MON_PRIO    = 0,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          c_req,
   input  logic          m_req,
   input  logic          c_we,
   input  logic          m_we,
   input  logic [31:4]   c_adr,
   input  logic [31:4]   m_adr,
   input  logic [127:0]  c_wdata,
   input  logic [127:0]  m_wdata,
   input  logic [15:0]   c_mask,
   input  logic [15:0]   m_mask,
   output logic          c_gnt,
   output logic          m_gnt,
   output logic          c_done,
   output logic          m_done,
   output logic          c_err,
   output logic          m_err,
   output logic [127:0]  rdata,
   output logic          mem_req,
   output logic          mem_we,
   output logic [31:4]   mem_adr,
   output logic [127:0]  mem_wdata,
   output logic [15:0]   mem_mask,
   input  logic          mem_ready,
   input  logic          mem_rvalid,
   input  logic [127:0]  mem_rdata,
   input  logic          mem_wresp,
   output logic          busy,
   output logic          err_spur
);

   state_e             state_q, state_d;
   req_id_e            last_q, last_d, owner_q, owner_d, winner;
   logic               we_q, we_d;
   logic [ADR_W-1:0]   adr_q, adr_d;
   logic [127:0]       wdata_q, wdata_d, rdata_q, rdata_d;
   logic [15:0]        mask_q, mask_d;
   logic               gnt_q, gnt_d, done_q, done_d, spur_q, spur_d;

   logic               sel_we;
   logic [ADR_W-1:0]   sel_adr;
   logic [127:0]       sel_wdata;
   logic [15:0]        sel_mask;

   arb_rr2 u_pick (
      .reqs   ({m_req, c_req}),
      .last   (last_q),
      .prio   (MON_PRIO != 0),
      .winner (winner)
   );

   assign sel_we    = (winner == REQ_MON) ? m_we    : c_we;
   assign sel_adr   = (winner == REQ_MON) ? m_adr   : c_adr;
   assign sel_wdata = (winner == REQ_MON) ? m_wdata : c_wdata;
   assign sel_mask  = (winner == REQ_MON) ? m_mask  : c_mask;

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;
`endif

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      owner_d = owner_q;
      we_d    = we_q;
      adr_d   = adr_q;
      wdata_d = wdata_q;
      mask_d  = mask_q;
      rdata_d = rdata_q;
      gnt_d   = 1'b0;
      done_d  = 1'b0;
      spur_d  = spur_q;
`ifdef ARB_TIMEOUT_EN
      err_d   = 1'b0;
      cnt_d   = (state_q == WAIT_R || state_q == WAIT_W) ? cnt_q + 1'b1 : '0;
`endif
      case (state_q)
         IDLE: begin
            if (mem_rvalid || mem_wresp) spur_d = 1'b1;
            if (c_req || m_req) begin
               state_d = ISSUE;
               gnt_d   = 1'b1;
               owner_d = winner;
               last_d  = winner;
               we_d    = sel_we;
               adr_d   = sel_adr;
               // Reads present zero data/mask on the port.
               wdata_d = sel_we ? sel_wdata : '0;
               mask_d  = sel_we ? sel_mask  : '0;
            end
         end
         ISSUE: begin
            if (mem_rvalid || mem_wresp) spur_d = 1'b1;
            if (mem_ready) state_d = we_q ? WAIT_W : WAIT_R;
         end
         WAIT_R: begin
            if (mem_wresp) spur_d = 1'b1;
            if (mem_rvalid) begin
               rdata_d = mem_rdata;
               done_d  = 1'b1;
               state_d = IDLE;
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt_q == CNT_LAST) begin
               rdata_d = TIMEOUT_DATA;
               done_d  = 1'b1;
               err_d   = 1'b1;
               state_d = IDLE;
            end
`endif
         end
         WAIT_W: begin
            if (mem_rvalid) spur_d = 1'b1;
            if (mem_wresp) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt_q == CNT_LAST) begin
               rdata_d = TIMEOUT_DATA;
               done_d  = 1'b1;
               err_d   = 1'b1;
               state_d = IDLE;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // Last-grant pointer resets to the monitor so the CPU wins the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= REQ_MON;
         owner_q <= REQ_CPU;
         we_q    <= 1'b0;
         adr_q   <= '0;
         wdata_q <= '0;
         mask_q  <= '0;
         rdata_q <= '0;
         gnt_q   <= 1'b0;
         done_q  <= 1'b0;
         spur_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         wdata_q <= wdata_d;
         mask_q  <= mask_d;
         rdata_q <= rdata_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         spur_q  <= spur_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
`endif

   logic [1:0] gnt_vec, done_vec, err_vec;

   for (genvar gi = 0; gi < 2; gi++) begin : g_req
      localparam req_id_e ID = (gi == 0) ? REQ_CPU : REQ_MON;
      assign gnt_vec[gi]  = gnt_q  && (owner_q == ID);
      assign done_vec[gi] = done_q && (owner_q == ID);
`ifdef ARB_TIMEOUT_EN
      assign err_vec[gi]  = done_vec[gi] && err_q;
`else
      assign err_vec[gi]  = 1'b0;
`endif
   end

   assign c_gnt  = gnt_vec[0];
   assign m_gnt  = gnt_vec[1];
   assign c_done = done_vec[0];
   assign m_done = done_vec[1];
   assign c_err  = err_vec[0];
   assign m_err  = err_vec[1];

   assign mem_req   = (state_q == ISSUE);
   assign mem_we    = mem_req & we_q;
   assign mem_adr   = mem_req ? adr_q   : '0;
   assign mem_wdata = mem_req ? wdata_q : '0;
   assign mem_mask  = mem_req ? mask_q  : '0;

   assign rdata    = rdata_q;
   assign busy     = (state_q != IDLE);
   assign err_spur = spur_q;

endmodule

// File: tb/tb_dram_port_arb.sv
// Bench for dram_port_arb: directed vector table, randomized transactions against a
// transaction-level model, and hand sequences for spurious responses, reset and the watchdog.
module tb_dram_port_arb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic c_req, m_req, c_we, m_we;
   logic [31:4] c_adr, m_adr;
   logic [127:0] c_wdata, m_wdata;
   logic [15:0] c_mask, m_mask;
   logic c_gnt, m_gnt, c_done, m_done, c_err, m_err;
   logic [127:0] rdata;
   logic mem_req, mem_we;
   logic [31:4] mem_adr;
   logic [127:0] mem_wdata;
   logic [15:0] mem_mask;
   logic mem_ready, mem_rvalid, mem_wresp;
   logic [127:0] mem_rdata;
   logic busy, err_spur;

   // Second instance (monitor priority) with an always-ready, always-responding memory.
   logic p1_c_gnt, p1_m_gnt, p1_c_done, p1_m_done, p1_c_err, p1_m_err;
   logic [127:0] p1_rdata, p1_mem_wdata;
   logic p1_mem_req, p1_mem_we, p1_busy, p1_err_spur;
   logic [31:4] p1_mem_adr;
   logic [15:0] p1_mem_mask;

   dram_port_arb #(.MON_PRIO(0), .TIMEOUT_CYC(8)) dut (
      .clk(clk), .rst(rst),
      .c_req(c_req), .m_req(m_req), .c_we(c_we), .m_we(m_we),
      .c_adr(c_adr), .m_adr(m_adr), .c_wdata(c_wdata), .m_wdata(m_wdata),
      .c_mask(c_mask), .m_mask(m_mask),
      .c_gnt(c_gnt), .m_gnt(m_gnt), .c_done(c_done), .m_done(m_done),
      .c_err(c_err), .m_err(m_err), .rdata(rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr),
      .mem_wdata(mem_wdata), .mem_mask(mem_mask),
      .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .mem_wresp(mem_wresp), .busy(busy), .err_spur(err_spur)
   );

   dram_port_arb #(.MON_PRIO(1), .TIMEOUT_CYC(8)) dut_p1 (
      .clk(clk), .rst(rst),
      .c_req(c_req), .m_req(m_req), .c_we(c_we), .m_we(m_we),
      .c_adr(c_adr), .m_adr(m_adr), .c_wdata(c_wdata), .m_wdata(m_wdata),
      .c_mask(c_mask), .m_mask(m_mask),
      .c_gnt(p1_c_gnt), .m_gnt(p1_m_gnt), .c_done(p1_c_done), .m_done(p1_m_done),
      .c_err(p1_c_err), .m_err(p1_m_err), .rdata(p1_rdata),
      .mem_req(p1_mem_req), .mem_we(p1_mem_we), .mem_adr(p1_mem_adr),
      .mem_wdata(p1_mem_wdata), .mem_mask(p1_mem_mask),
      .mem_ready(1'b1), .mem_rvalid(1'b1), .mem_rdata(128'h0),
      .mem_wresp(1'b1), .busy(p1_busy), .err_spur(p1_err_spur)
   );

   int checks = 0;
   int errors = 0;
   int ntx = 0;
   logic mdl_last;              // 1 = monitor granted last
   logic [127:0] mdl_rdata;
   logic win;
   int mg;

   typedef struct {
      logic rc, rm, cwe, mwe;
      logic [31:4] cadr, madr;
      logic [15:0] cmask, mmask;
      logic [127:0] wd;
      int rdy, rsp;
      logic [127:0] rd;
      logic exp_mon;
   } vec_t;
   vec_t vecs[5];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [127:0] r128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic raise_c(input logic we, input logic [31:4] adr, input logic [15:0] mk, input logic [127:0] wd);
      c_req = 1'b1; c_we = we; c_adr = adr; c_mask = mk; c_wdata = wd;
   endtask

   task automatic raise_m(input logic we, input logic [31:4] adr, input logic [15:0] mk, input logic [127:0] wd);
      m_req = 1'b1; m_we = we; m_adr = adr; m_mask = mk; m_wdata = wd;
   endtask

   // One full transaction: expects the grant one cycle after the call, holds mem_ready low for
   // rdy cycles, delays the response by rsp cycles, then checks the completion.
   task automatic serve(input logic win_mon, input int rdy, input int rsp, input logic [127:0] rd);
      logic we_e;
      logic [31:4] adr_e;
      logic [15:0] mk_e;
      logic [127:0] wd_e;
      int lat;
      we_e  = win_mon ? m_we : c_we;
      adr_e = win_mon ? m_adr : c_adr;
      mk_e  = !we_e ? 16'h0 : (win_mon ? m_mask : c_mask);
      wd_e  = !we_e ? 128'h0 : (win_mon ? m_wdata : c_wdata);
      lat = 0;
      do begin
         tick();
         lat++;
         chk("done_pulse", {m_done, c_done}, 2'b00);
      end while (!(c_gnt || m_gnt) && lat < 6);
      chk("gnt_lat", lat, 1);
      chk("gnt_who", {m_gnt, c_gnt}, win_mon ? 2'b10 : 2'b01);
      chk("busy_issue", busy, 1'b1);
      mdl_last = win_mon;
      if (win_mon) begin
         m_req = 1'b0; m_we = 1'($urandom); m_adr = 28'($urandom); m_mask = 16'($urandom); m_wdata = r128();
      end else begin
         c_req = 1'b0; c_we = 1'($urandom); c_adr = 28'($urandom); c_mask = 16'($urandom); c_wdata = r128();
      end
      for (int i = 0; i <= rdy; i++) begin
         mem_ready = (i == rdy);
         if (i > 0) chk("gnt_once", {m_gnt, c_gnt}, 2'b00);
         chk("mem_cmd", {mem_req, mem_we, mem_adr, mem_mask}, {1'b1, we_e, adr_e, mk_e});
         chk("mem_wdata", mem_wdata, wd_e);
         tick();
      end
      mem_ready = 1'b0;
      chk("cmd_drop", mem_req, 1'b0);
      for (int i = 0; i < rsp; i++) begin
         chk("no_early_done", {busy, m_done, c_done}, 3'b100);
         tick();
      end
      if (we_e) begin
         mem_wresp = 1'b1;
      end else begin
         mem_rvalid = 1'b1;
         mem_rdata = rd;
         mdl_rdata = rd;
      end
      tick();
      mem_wresp = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata = r128();
      chk("done_who", {m_done, c_done}, win_mon ? 2'b10 : 2'b01);
      chk("done_err", {m_err, c_err}, 2'b00);
      chk("busy_done", busy, 1'b0);
      chk("rdata", rdata, mdl_rdata);
      $display("txn %0d: %s %s adr=%h rdy=%0d rsp=%0d", ntx, win_mon ? "MON" : "CPU", we_e ? "WR" : "RD", adr_e, rdy, rsp);
      ntx++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      c_req = 0; m_req = 0; c_we = 0; m_we = 0; c_adr = '0; m_adr = '0;
      c_wdata = '0; m_wdata = '0; c_mask = '0; m_mask = '0;
      mem_ready = 0; mem_rvalid = 0; mem_wresp = 0; mem_rdata = '0;
      mdl_last = 1'b1;
      mdl_rdata = '0;
      tick();
      tick();
      chk("rst_ctl", {busy, c_gnt, m_gnt, c_done, m_done, c_err, m_err, mem_req, mem_we, err_spur}, 10'b0);
      chk("rst_adr", {mem_adr, mem_mask}, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_rdata", rdata, 0);
      rst = 1'b0;

      // Ties first: CPU wins after reset, then grants alternate while both are held.
      vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 28'h100, 28'h200, 16'hFFFF, 16'h000F,
                  128'h1111_2222_3333_4444_5555_6666_7777_8888, 0, 0,
                  128'h0123456789ABCDEF0123456789ABCDEF, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 28'h300, 28'h0, 16'hFFFF, 16'h0,
                  128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_0F0F, 5, 2, 128'h0, 1'b1};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 28'h0, 28'h400, 16'h0, 16'h00F0,
                  128'h0, 1, 1, 128'h0, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 28'h0, 28'h0, 16'h0, 16'h0,
                  128'h0, 0, 3, 128'hCAFEF00D_0BADC0DE_12345678_9ABCDEF0, 1'b1};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 28'h100, 28'h0, 16'h0, 16'h0,
                  128'h0, 0, 0, 128'hFEDCBA9876543210FEDCBA9876543210, 1'b0};
      for (int v = 0; v < 5; v++) begin
         if (vecs[v].rc) raise_c(vecs[v].cwe, vecs[v].cadr, vecs[v].cmask, vecs[v].wd);
         if (vecs[v].rm) raise_m(vecs[v].mwe, vecs[v].madr, vecs[v].mmask, ~vecs[v].wd);
         serve(vecs[v].exp_mon, vecs[v].rdy, vecs[v].rsp, vecs[v].rd);
      end

      for (int t = 0; t < 60; t++) begin
         if (!c_req && ($urandom_range(0, 1) == 1)) raise_c(1'($urandom), 28'($urandom), 16'($urandom), r128());
         if (!m_req && ($urandom_range(0, 1) == 1)) raise_m(1'($urandom), 28'($urandom), 16'($urandom), r128());
         if (!c_req && !m_req) raise_c(1'($urandom), 28'($urandom), 16'($urandom), r128());
         win = (c_req && m_req) ? ~mdl_last : m_req;
         serve(win, $urandom_range(0, 3), $urandom_range(0, 3), r128());
      end
      c_req = 1'b0;
      m_req = 1'b0;
      chk("no_spur", err_spur, 1'b0);

      mem_rvalid = 1'b1;
      mem_rdata = r128();
      tick();
      mem_rvalid = 1'b0;
      chk("spur_set", err_spur, 1'b1);
      chk("spur_busy", busy, 1'b0);
      chk("spur_done", {m_done, c_done}, 2'b00);
      chk("spur_rdata", rdata, mdl_rdata);
      tick();
      tick();
      tick();
      chk("spur_sticky", err_spur, 1'b1);

      // Monitor-priority instance: held tie means the monitor wins every arbitration.
      raise_c(1'b0, 28'h10, 16'h0, 128'h0);
      raise_m(1'b0, 28'h20, 16'h0, 128'h0);
      mg = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("p1_no_cpu", p1_c_gnt, 1'b0);
         mg += int'(p1_m_gnt);
      end
      chk("p1_mon_gnts", mg, 4);
      c_req = 1'b0;
      m_req = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;

      // Reset while waiting for read data.
      raise_c(1'b0, 28'h55, 16'h0, 128'h0);
      tick();
      chk("rst_gnt", c_gnt, 1'b1);
      c_req = 1'b0;
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      chk("rst_wait", busy, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", {m_done, c_done}, 2'b00);
      chk("rst_spur", err_spur, 1'b0);
      mdl_last = 1'b1;
      mdl_rdata = '0;
      tick();
      chk("rst_nodone", {m_done, c_done}, 2'b00);
      mem_rvalid = 1'b1;
      mem_rdata = r128();
      tick();
      mem_rvalid = 1'b0;
      chk("late_spur", err_spur, 1'b1);
      chk("late_done", {m_done, c_done}, 2'b00);
      chk("late_rdata", rdata, 128'h0);
      raise_c(1'b0, 28'h77, 16'h0, 128'h0);
      serve(1'b0, 1, 1, r128());

`ifdef ARB_TIMEOUT_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      raise_c(1'b0, 28'h99, 16'h0, 128'h0);
      tick();
      chk("to_gnt", c_gnt, 1'b1);
      c_req = 1'b0;
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("to_early", {c_err, c_done}, 2'b00);
      end
      tick();
      chk("to_done", {m_done, c_err, c_done}, 3'b011);
      chk("to_rdata", rdata, {4{32'hDEADBEEF}});
      chk("to_busy", busy, 1'b0);
      chk("to_nospur", err_spur, 1'b0);
      mem_rvalid = 1'b1;
      tick();
      mem_rvalid = 1'b0;
      chk("to_late_spur", err_spur, 1'b1);
      chk("to_late_done", c_done, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dram_port_arb.md
Name: dram_port_arb

Overview:
- Two-requester arbiter and sequencer for the single 128-bit data-RAM line port.
- Requester 0 is the CPU data-cache refill/writeback path; requester 1 is the UART monitor (dump/write/flush path).
- Grants one requester at a time and issues its read or write to memory. Only one transaction is outstanding.
- Returns read data or write completion to the owning requester, then re-arbitrates.

Parameters:
- MON_PRIO, 0: 0 = round-robin between requesters; 1 = monitor always wins ties.
- TIMEOUT_CYC, 1024: wait-state watchdog limit in cycles (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- c_req, m_req  in  1 each  CPU / monitor request, held until grant.
- c_we, m_we  in  1 each  1 = write, 0 = read.
- c_adr, m_adr  in  [31:4] each  line address.
- c_wdata, m_wdata  in  128 each  write data.
- c_mask, m_mask  in  16 each  byte enables for writes.
- c_gnt, m_gnt  out  1 each  one-cycle pulse: command latched.
- c_done, m_done  out  1 each  one-cycle pulse: transaction complete.
- c_err, m_err  out  1 each  qualifies done: transaction timed out.
- rdata  out  128  read data; valid with the owner's done.
- mem_req  out  1  command valid.
- mem_we  out  1  write/read select.
- mem_adr  out  [31:4]  line address.
- mem_wdata  out  128  write data.
- mem_mask  out  16  byte enables.
- mem_ready  in  1  command accepted when mem_req & mem_ready.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  128  read data.
- mem_wresp  in  1  write complete.
- busy  out  1  state != IDLE.
- err_spur  out  1  sticky: response seen outside a wait state.

Behaviour:
- Reset: all outputs 0, including rdata and err_spur. State is IDLE. Last-grant pointer is set to monitor, so the CPU wins the first tie.
- States: IDLE, ISSUE, WAIT_R, WAIT_W.
- IDLE, when any req is sampled high in cycle N:
  - MON_PRIO=0: the requester not granted last wins a tie. MON_PRIO=1: the monitor wins a tie.
  - The winner's we/adr/wdata/mask are latched, and the pointer is updated.
  - Cycle N+1: state ISSUE, winner's gnt=1 for exactly one cycle, mem_req=1 with the latched fields.
- Reads drive mem_mask=0 and mem_wdata=0.
- After gnt the requester may drop or change req and its fields. A req still high after done is a new request.
- ISSUE: hold mem_req and fields stable until mem_ready. mem_ready may be high in the first ISSUE cycle. On the handshake cycle go to WAIT_R (read) or WAIT_W (write); mem_req is 0 from the next cycle.
- WAIT_R: on mem_rvalid, register mem_rdata into rdata and pulse the owner's done next cycle. rdata holds until the next read completes.
- WAIT_W: on mem_wresp, pulse the owner's done next cycle.
- Both wait states return to IDLE in the same cycle done asserts.
- Minimum latency, with mem_ready and the response both immediate: req@N → gnt@N+1 → done@N+3. Back-to-back grants are at least 3 cycles apart.
- Spurious responses: mem_rvalid or mem_wresp in IDLE/ISSUE, or the wrong kind in a wait state, is ignored and sets err_spur. err_spur is cleared only by rst.
- The loser's req stays pending. Starvation is impossible with MON_PRIO=0; with MON_PRIO=1 it is the monitor's responsibility.
- Reset mid-operation: return to IDLE immediately, abandon the transaction, no done. A late memory response after reset sets err_spur.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined: a counter clears on entry to WAIT_R/WAIT_W and increments each wait cycle. When it reaches TIMEOUT_CYC-1 with no response:
  - next cycle pulses the owner's done with err=1;
  - rdata = {4{32'hDEADBEEF}};
  - state returns to IDLE.
  - A response arriving later sets err_spur.
- Undefined: waits indefinitely, c_err/m_err tied 0, TIMEOUT_CYC unused, no counter logic.

Decomposition:
- Package dram_arb_pkg:
  - state enum (IDLE/ISSUE/WAIT_R/WAIT_W);
  - requester IDs REQ_CPU=0, REQ_MON=1;
  - TIMEOUT_DATA constant;
  - line-address width constant.
- Sub-module arb_rr2: combinational two-input picker (inputs reqs, last, prio; outputs winner). Everything else stays in dram_port_arb.

Test Plan:
- Only c_req, read adr 0x100, mem_ready and rvalid immediate, mem_rdata=0x0123...EF → c_gnt@N+1, c_done@N+3, rdata=0x0123...EF, m_* silent.
- c_req and m_req together after reset, both held, MON_PRIO=0 → grants alternate CPU, MON, CPU; with MON_PRIO=1 → MON wins every tie.
- Monitor write, mask 0x000F, mem_ready low for 5 cycles → mem_req and fields stable for 6 cycles, m_done one cycle after mem_wresp.
- mem_rvalid pulsed in IDLE → err_spur=1 and stays set, no done, state unchanged.
- rst asserted in WAIT_R → next cycle busy=0, no done; subsequent request is served normally.
- ARB_TIMEOUT_EN, TIMEOUT_CYC=8, CPU read with no rvalid → c_done with c_err=1 eight cycles after entering WAIT_R, rdata=DEADBEEF×4.
